// File: rtl/bitreverse_arbiter_if.sv
// ---------------------------------------------------------------------------
// bitreverse_arbiter_if
//
// Bundles the two requester channels and the downstream output of the
// bit-reversal arbiter into a single interface.
//
// Signals:
//   i0_dat/i0_val/i0_eop/i0_rev  channel 0 word, valid, last word, mirror enable
//   o0_rdy                       channel 0 ready (word taken on i0_val & o0_rdy)
//   i1_dat/i1_val/i1_eop/i1_rev  channel 1, same meaning
//   o1_rdy                       channel 1 ready
//   o_dat/o_val/o_eop/o_ch       registered output word, valid, last word, source
//   i_rdy                        downstream ready (word taken on o_val & i_rdy)
//
// Modports:
//   slave  - the arbiter itself
//   master - the environment driving the channels and sinking the output
// ---------------------------------------------------------------------------
interface bitreverse_arbiter_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] i0_dat;
    logic             i0_val;
    logic             i0_eop;
    logic             i0_rev;
    logic             o0_rdy;

    logic [WIDTH-1:0] i1_dat;
    logic             i1_val;
    logic             i1_eop;
    logic             i1_rev;
    logic             o1_rdy;

    logic [WIDTH-1:0] o_dat;
    logic             o_val;
    logic             o_eop;
    logic             o_ch;
    logic             i_rdy;

    modport slave (
        input  i0_dat, i0_val, i0_eop, i0_rev,
        output o0_rdy,
        input  i1_dat, i1_val, i1_eop, i1_rev,
        output o1_rdy,
        output o_dat, o_val, o_eop, o_ch,
        input  i_rdy
    );

    modport master (
        output i0_dat, i0_val, i0_eop, i0_rev,
        input  o0_rdy,
        output i1_dat, i1_val, i1_eop, i1_rev,
        input  o1_rdy,
        input  o_dat, o_val, o_eop, o_ch,
        output i_rdy
    );
endinterface

// File: rtl/bitreverse_arbiter.sv
// ---------------------------------------------------------------------------
// bitreverse_arbiter
//
// Two-channel round-robin packet arbiter sharing one registered bit-reversal
// stage. A grant is held for a whole packet; each accepted word is either
// mirrored (bit i <- bit WIDTH-1-i) or passed through according to its own
// rev bit, and lands in a single output register.
//
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous reset, active high
//   bus    - bitreverse_arbiter_if.slave: both request channels, their
//            readys, and the registered output with downstream ready
// ---------------------------------------------------------------------------
module bitreverse_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    bitreverse_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             ptr;
    logic             ptr_next;

    logic [WIDTH-1:0] dat_q;
    logic             val_q;
    logic             eop_q;
    logic             ch_q;

    logic             can_load;
    logic             rdy0;
    logic             rdy1;
    logic             acc0;
    logic             acc1;
    logic             acc;

    logic [WIDTH-1:0] sel_dat;
    logic             sel_eop;
    logic             sel_rev;
    logic             sel_ch;
    logic [WIDTH-1:0] load_dat;

    function automatic logic [WIDTH-1:0] mirror(input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = d[WIDTH-1-i];
        end
        return r;
    endfunction

    // The output register can take a new word when it is empty or being
    // drained this cycle. Readys use only state and output-side signals so
    // there is never a path from a valid back to a ready.
    assign can_load = !val_q || bus.i_rdy;
    assign rdy0     = (state == GNT0) && can_load;
    assign rdy1     = (state == GNT1) && can_load;
    assign acc0     = rdy0 && bus.i0_val;
    assign acc1     = rdy1 && bus.i1_val;
    assign acc      = acc0 || acc1;

    // Only the granted channel is ever accepted, so the grant alone selects
    // which channel's word feeds the shared mirror stage.
    always_comb begin
        sel_ch  = (state == GNT1);
        sel_dat = bus.i0_dat;
        sel_eop = bus.i0_eop;
        sel_rev = bus.i0_rev;
        if (sel_ch) begin
            sel_dat = bus.i1_dat;
            sel_eop = bus.i1_eop;
            sel_rev = bus.i1_rev;
        end
        load_dat = sel_rev ? mirror(sel_dat) : sel_dat;
    end

    // Grant FSM. On the eop handover the other channel is preferred if it
    // is already waiting, which gives back-to-back packets with no bubble.
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        case (state)
            IDLE: begin
                if (bus.i0_val && bus.i1_val) begin
                    state_next = ptr ? GNT1 : GNT0;
                end else if (bus.i0_val) begin
                    state_next = GNT0;
                end else if (bus.i1_val) begin
                    state_next = GNT1;
                end
            end
            GNT0: begin
                if (acc0 && bus.i0_eop) begin
                    ptr_next = 1'b1;
                    if (bus.i1_val) begin
                        state_next = GNT1;
                    end else if (bus.i0_val) begin
                        state_next = GNT0;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            GNT1: begin
                if (acc1 && bus.i1_eop) begin
                    ptr_next = 1'b0;
                    if (bus.i0_val) begin
                        state_next = GNT0;
                    end else if (bus.i1_val) begin
                        state_next = GNT1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Grant state and round-robin pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            ptr   <= 1'b0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
        end
    end

    // Output register: load on acceptance, otherwise drop valid once the
    // downstream takes the word. Data, eop and channel keep their last value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dat_q <= '0;
            val_q <= 1'b0;
            eop_q <= 1'b0;
            ch_q  <= 1'b0;
        end else if (acc) begin
            dat_q <= load_dat;
            val_q <= 1'b1;
            eop_q <= sel_eop;
            ch_q  <= sel_ch;
        end else if (val_q && bus.i_rdy) begin
            val_q <= 1'b0;
        end
    end

    assign bus.o0_rdy = rdy0;
    assign bus.o1_rdy = rdy1;
    assign bus.o_dat  = dat_q;
    assign bus.o_val  = val_q;
    assign bus.o_eop  = eop_q;
    assign bus.o_ch   = ch_q;

endmodule

// File: tb/tb_bitreverse_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bitreverse_arbiter
//
// Directed bench for bitreverse_arbiter: a vector table covering a mirrored
// ch0 packet, alternating back-to-back packets and a downstream stall, plus
// hand-written sequences for async reset mid-packet and a WIDTH=1 build.
// ---------------------------------------------------------------------------
module tb_bitreverse_arbiter;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    bitreverse_arbiter_if #(.WIDTH(32)) bus ();
    bitreverse_arbiter_if #(.WIDTH(1))  bus1 ();

    bitreverse_arbiter #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    bitreverse_arbiter #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    typedef struct {
        logic        i0_val;
        logic [31:0] i0_dat;
        logic        i0_eop;
        logic        i0_rev;
        logic        i1_val;
        logic [31:0] i1_dat;
        logic        i1_eop;
        logic        i1_rev;
        logic        i_rdy;
        logic        x_rdy0;
        logic        x_rdy1;
        logic        x_val;
        logic [31:0] x_dat;
        logic        x_eop;
        logic        x_ch;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vecs [NVEC];

    // One comparison: counted, and reported with a FAIL line on mismatch.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        bus.i0_val = v.i0_val;
        bus.i0_dat = v.i0_dat;
        bus.i0_eop = v.i0_eop;
        bus.i0_rev = v.i0_rev;
        bus.i1_val = v.i1_val;
        bus.i1_dat = v.i1_dat;
        bus.i1_eop = v.i1_eop;
        bus.i1_rev = v.i1_rev;
        bus.i_rdy  = v.i_rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.i0_val = 0; bus.i0_dat = '0; bus.i0_eop = 0; bus.i0_rev = 0;
        bus.i1_val = 0; bus.i1_dat = '0; bus.i1_eop = 0; bus.i1_rev = 0;
        bus.i_rdy  = 1;
        bus1.i0_val = 0; bus1.i0_dat = '0; bus1.i0_eop = 0; bus1.i0_rev = 0;
        bus1.i1_val = 0; bus1.i1_dat = '0; bus1.i1_eop = 0; bus1.i1_rev = 0;
        bus1.i_rdy  = 1;

        // Fields: i0 val,dat,eop,rev | i1 val,dat,eop,rev | i_rdy |
        //         rdy0,rdy1 this cycle | o_val,o_dat,o_eop,o_ch after the edge
        // ch0 3-word mirrored packet
        vecs[0]  = '{1, 32'h0000_0001, 0, 1, 0, 32'h0, 0, 0, 1, 0, 0, 0, 32'h0000_0000, 0, 0};
        vecs[1]  = '{1, 32'h0000_0001, 0, 1, 0, 32'h0, 0, 0, 1, 1, 0, 1, 32'h8000_0000, 0, 0};
        vecs[2]  = '{1, 32'h8000_0000, 0, 1, 0, 32'h0, 0, 0, 1, 1, 0, 1, 32'h0000_0001, 0, 0};
        vecs[3]  = '{1, 32'h0000_FFFF, 1, 1, 0, 32'h0, 0, 0, 1, 1, 0, 1, 32'hFFFF_0000, 1, 0};
        vecs[4]  = '{0, 32'h0,         0, 0, 0, 32'h0, 0, 0, 1, 1, 0, 0, 32'hFFFF_0000, 1, 0};
        // both channels valid, 2-word packets, alternating without bubbles
        vecs[5]  = '{1, 32'h0000_A000, 0, 0, 1, 32'h0000_B000, 0, 0, 1, 1, 0, 1, 32'h0000_A000, 0, 0};
        vecs[6]  = '{1, 32'h0000_A001, 1, 0, 1, 32'h0000_B000, 0, 0, 1, 1, 0, 1, 32'h0000_A001, 1, 0};
        vecs[7]  = '{1, 32'h0000_000A, 0, 1, 1, 32'h0000_B000, 0, 0, 1, 0, 1, 1, 32'h0000_B000, 0, 1};
        vecs[8]  = '{1, 32'h0000_000A, 0, 1, 1, 32'h0000_B001, 1, 0, 1, 0, 1, 1, 32'h0000_B001, 1, 1};
        vecs[9]  = '{1, 32'h0000_000A, 0, 1, 1, 32'h0000_B002, 0, 0, 1, 1, 0, 1, 32'h5000_0000, 0, 0};
        vecs[10] = '{1, 32'h0000_A003, 1, 0, 1, 32'h0000_B002, 0, 0, 1, 1, 0, 1, 32'h0000_A003, 1, 0};
        vecs[11] = '{1, 32'h0000_A004, 0, 0, 1, 32'h0000_B002, 0, 0, 1, 0, 1, 1, 32'h0000_B002, 0, 1};
        vecs[12] = '{0, 32'h0,         0, 0, 0, 32'h0,         0, 0, 1, 0, 1, 0, 32'h0000_B002, 0, 1};
        // ch1 packet with a 4-cycle downstream stall on the second word
        vecs[13] = '{0, 32'h0, 0, 0, 1, 32'h1234_5678, 0, 0, 1, 0, 1, 1, 32'h1234_5678, 0, 1};
        vecs[14] = '{0, 32'h0, 0, 0, 1, 32'h9ABC_DEF0, 1, 0, 0, 0, 0, 1, 32'h1234_5678, 0, 1};
        vecs[15] = '{0, 32'h0, 0, 0, 1, 32'h9ABC_DEF0, 1, 0, 0, 0, 0, 1, 32'h1234_5678, 0, 1};
        vecs[16] = '{0, 32'h0, 0, 0, 1, 32'h9ABC_DEF0, 1, 0, 0, 0, 0, 1, 32'h1234_5678, 0, 1};
        vecs[17] = '{0, 32'h0, 0, 0, 1, 32'h9ABC_DEF0, 1, 0, 0, 0, 0, 1, 32'h1234_5678, 0, 1};
        vecs[18] = '{0, 32'h0, 0, 0, 1, 32'h9ABC_DEF0, 1, 0, 1, 0, 1, 1, 32'h9ABC_DEF0, 1, 1};
        vecs[19] = '{0, 32'h0, 0, 0, 0, 32'h0,         0, 0, 1, 0, 1, 0, 32'h9ABC_DEF0, 1, 1};

        // Clean reset, released just after a rising edge.
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        checkOutput("reset o_val", {31'b0, bus.o_val}, 32'h0);
        checkOutput("reset o_dat", bus.o_dat, 32'h0);

        for (int k = 0; k < NVEC; k++) begin
            applyStimulus(vecs[k]);
            #1;
            checkOutput($sformatf("v%0d o0_rdy", k), {31'b0, bus.o0_rdy}, {31'b0, vecs[k].x_rdy0});
            checkOutput($sformatf("v%0d o1_rdy", k), {31'b0, bus.o1_rdy}, {31'b0, vecs[k].x_rdy1});
            tick();
            checkOutput($sformatf("v%0d o_val", k), {31'b0, bus.o_val}, {31'b0, vecs[k].x_val});
            checkOutput($sformatf("v%0d o_dat", k), bus.o_dat, vecs[k].x_dat);
            checkOutput($sformatf("v%0d o_eop", k), {31'b0, bus.o_eop}, {31'b0, vecs[k].x_eop});
            checkOutput($sformatf("v%0d o_ch", k),  {31'b0, bus.o_ch},  {31'b0, vecs[k].x_ch});
        end

        // Reset mid-packet: first move ptr to 1 with a single-word ch0
        // packet, then leave a ch0 word sitting in the output register.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.i0_val = 1; bus.i0_dat = 32'h11; bus.i0_eop = 1; bus.i0_rev = 0;
        bus.i_rdy  = 1;
        tick();
        tick();
        bus.i0_dat = 32'h22; bus.i0_eop = 0;
        tick();
        bus.i0_val = 0; bus.i_rdy = 0;
        #1;
        checkOutput("mid o_val", {31'b0, bus.o_val}, 32'h1);
        checkOutput("mid o_dat", bus.o_dat, 32'h22);
        #1 reset = 1'b1;
        #1;
        checkOutput("async o_val",  {31'b0, bus.o_val},  32'h0);
        checkOutput("async o_dat",  bus.o_dat,           32'h0);
        checkOutput("async o_eop",  {31'b0, bus.o_eop},  32'h0);
        checkOutput("async o_ch",   {31'b0, bus.o_ch},   32'h0);
        checkOutput("async o0_rdy", {31'b0, bus.o0_rdy}, 32'h0);
        checkOutput("async o1_rdy", {31'b0, bus.o1_rdy}, 32'h0);

        // Release with both channels requesting: ptr must be back to 0.
        bus.i0_val = 1; bus.i0_dat = 32'h33; bus.i0_eop = 0;
        bus.i1_val = 1; bus.i1_dat = 32'h44; bus.i1_eop = 0;
        bus.i_rdy  = 1;
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        checkOutput("rel1 o_val",  {31'b0, bus.o_val},  32'h0);
        checkOutput("rel1 o0_rdy", {31'b0, bus.o0_rdy}, 32'h0);
        checkOutput("rel1 o1_rdy", {31'b0, bus.o1_rdy}, 32'h0);
        tick();
        checkOutput("rel2 o0_rdy", {31'b0, bus.o0_rdy}, 32'h1);
        checkOutput("rel2 o1_rdy", {31'b0, bus.o1_rdy}, 32'h0);
        bus.i0_val = 0; bus.i1_val = 0;

        // WIDTH=1 build: mirror is identity, output is input one cycle later.
        bus1.i0_val = 1; bus1.i0_rev = 1; bus1.i0_eop = 0; bus1.i0_dat = 1'b0;
        bus1.i_rdy  = 1;
        tick();
        for (int k = 0; k < 8; k++) begin
            bus1.i0_dat = 1'(k % 2);
            tick();
            checkOutput($sformatf("w1 o_val %0d", k), {31'b0, bus1.o_val}, 32'h1);
            checkOutput($sformatf("w1 o_dat %0d", k), {31'b0, bus1.o_dat}, 32'(k % 2));
        end
        bus1.i0_val = 0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/bitreverse_arbiter.md
# bitreverse_arbiter

Two-channel packet arbiter that shares one registered bit-reversal stage between two streaming requesters. Each channel can request mirroring of every word (bit i of output = bit WIDTH-1-i of input) or pass the word straight through. Round-robin, packet-locked grant, with a single output register. The block sits in front of CRC/scrambler logic on the link layer, where transmit and receive paths need bit-order conversion but only one converter is instantiated.

## Interface
- WIDTH, 32, data width of both channels and the output (≥1)
- reset  in  1  asynchronous reset, active-high
- clk  in  1  the single clock; all logic on rising edge
- i0_dat  in  WIDTH  channel 0 word
- i0_val  in  1  channel 0 word valid
- i0_eop  in  1  channel 0 last word of packet, qualified by i0_val
- i0_rev  in  1  channel 0 reverse enable for this word, qualified by i0_val
- o0_rdy  out  1  channel 0 word accepted when i0_val & o0_rdy
- i1_dat, i1_val, i1_eop, i1_rev  in  WIDTH/1/1/1  channel 1, same meaning
- o1_rdy  out  1  channel 1 ready
- o_dat  out  WIDTH  output word, reversed or not per source word's rev bit
- o_val  out  1  output word valid
- o_eop  out  1  output last word of packet
- o_ch  out  1  source channel of the current output word
- i_rdy  in  1  downstream ready; word taken when o_val & i_rdy

## Operation
- States: IDLE, GNT0, GNT1. Round-robin pointer ptr (0 or 1) gives the channel with priority.
- IDLE: o0_rdy = o1_rdy = 0.
  - If exactly one i*_val is high, go to that channel's GNT state next cycle.
  - If both are high, go to GNTptr.
  - If none, stay in IDLE.
- GNTn: o{n}_rdy = (!o_val | i_rdy); the other channel's ready = 0.
  - Grant is locked until a word with i{n}_eop = 1 is accepted.
  - Cycle in which the eop word is accepted:
    - ptr ← 1−n.
    - Next state is GNT(1−n) if i{1−n}_val is high that cycle.
    - Otherwise GNTn if i{n}_val is high that cycle. The word on the bus then is already the next one, unaccepted.
    - Otherwise IDLE.
- Output register is loaded on input acceptance:
  - o_dat ← i{n}_rev ? mirror(i{n}_dat) : i{n}_dat.
  - o_eop ← i{n}_eop; o_ch ← n; o_val ← 1.
- If o_val & i_rdy with no acceptance in the same cycle, o_val ← 0. o_dat, o_eop and o_ch hold their last values.
- Held output: while o_val & !i_rdy, o_dat, o_eop and o_ch are stable and no input is accepted.
- Reverse mode is per word; mixing rev values inside a packet is legal and each word is honoured.
- WIDTH = 1: mirror is identity.

## Timing
- Reset (async assert, released synchronously by system) values:
  - State IDLE, ptr 0.
  - o0_rdy 0, o1_rdy 0.
  - o_val 0, o_dat 0, o_eop 0, o_ch 0.
- Arbitration latency: 1 cycle. A request arriving in IDLE at cycle t gets ready at cycle t+1.
- Data latency: a word accepted at edge t appears on o_dat/o_val after edge t.
- Sustained throughput: 1 word/clk with i_rdy held high, including back-to-back packets across channels. There is no bubble at an eop handover when the other channel is already valid.
- Downstream stall: i_rdy low with o_val high drops the granted ready combinationally in the same cycle.
- Reset mid-packet: grant and output register are discarded, with no partial word emitted after reset. Upstream packet framing is the requester's responsibility.
- Ready outputs depend combinationally on state, o_val and i_rdy only; never on i*_val. There is no combinational loop.

## Test plan
- Reset with both channels valid, then release:
  - o_val = 0 and both readys = 0 in the first cycle.
  - Cycle 2: o0_rdy = 1 (ptr = 0).
- Ch0 sends a 3-word packet (0x00000001, 0x80000000, 0x0000FFFF), rev = 1, i_rdy = 1:
  - Output is 0x80000000, 0x00000001, 0xFFFF0000 on consecutive cycles.
  - o_ch = 0; o_eop only on the third word.
- Both channels continuously valid, 2-word packets, i_rdy = 1:
  - Output alternates ch0, ch1, ch0 packet-wise with no idle cycle between packets.
  - Packets never interleave.
- Ch1 packet with rev = 0, word 0x12345678; i_rdy low for 4 cycles mid-packet:
  - o_dat holds 0x12345678, o_val = 1, o1_rdy = 0 during the stall.
  - On resume, the next word follows with no loss or duplicate.
- Assert reset while ch0 is mid-packet and o_val = 1:
  - All outputs return to reset values asynchronously.
  - After release, arbitration restarts from IDLE with ptr = 0.
- WIDTH = 1 build, rev = 1, data toggling 0,1:
  - Output equals input delayed 1 cycle.
